// File: rtl/led_pio_blink_pkg.sv
// Shared definitions for the LED PIO: register word addresses and CTRL bit positions.
package led_pio_blink_pkg;

   typedef enum logic [2:0] {
      ADDR_DATA   = 3'd0,
      ADDR_BLINK  = 3'd1,
      ADDR_PERIOD = 3'd2,
      ADDR_CTRL   = 3'd3,
      ADDR_OUTSET = 3'd4,
      ADDR_OUTCLR = 3'd5,
      ADDR_TOGGLE = 3'd6,
      ADDR_RSVD   = 3'd7
   } reg_addr_e;

   localparam int unsigned CTRL_RUN   = 0;
   localparam int unsigned CTRL_PHASE = 1;

endpackage

// File: rtl/led_pio_blink_if.sv
// Avalon-MM slave bus bundle for the LED PIO.
interface led_pio_blink_if;

   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );

endinterface

// File: rtl/led_blink_prescaler.sv
// Down-counting blink prescaler; phase flips each time cnt wraps through zero.
module led_blink_prescaler #(
   parameter int unsigned      CNT_W     = 24,
   parameter logic [CNT_W-1:0] RESET_CNT = '1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             run,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             phase,
   output logic             phase_nxt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             phase_q;

   // load_val is the next PERIOD value, so it serves both the explicit
   // PERIOD-write load and the terminal-count reload.
   always_comb begin
      cnt_d     = cnt_q;
      phase_nxt = phase_q;
      if (load) begin
         cnt_d     = load_val;
         phase_nxt = 1'b1;
      end else if (!run) begin
         phase_nxt = 1'b1;
      end else if (cnt_q == '0) begin
         cnt_d     = load_val;
         phase_nxt = ~phase_q;
      end else begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= RESET_CNT;
         phase_q <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_nxt;
      end
   end

   assign phase = phase_q;

endmodule

// File: rtl/led_pio_blink.sv
// Avalon-MM LED output PIO with atomic set/clear/toggle and per-bit hardware blink.
module led_pio_blink
   import led_pio_blink_pkg::*;
#(
   parameter int unsigned      WIDTH          = 9,
   parameter int unsigned      CNT_W          = 24,
   parameter logic [WIDTH-1:0] RESET_VALUE    = '0,
   parameter logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(12_499_999)
) (
   input  logic                clk,
   input  logic                reset_n,
   led_pio_blink_if.slave      bus,
   output logic [WIDTH-1:0]    out_port
);

   logic [WIDTH-1:0] data_q,   data_d;
   logic [WIDTH-1:0] blink_q,  blink_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             run_q,    run_d;
   logic             wr;
   logic             period_load;
   logic             phase;
   logic             phase_nxt;
   logic             wd_unused;
   reg_addr_e        addr;
   logic [WIDTH-1:0] wd_w;
   logic [CNT_W-1:0] wd_c;

   assign wr        = bus.chipselect & ~bus.write_n;
   assign addr      = reg_addr_e'(bus.address);
   assign wd_w      = bus.writedata[WIDTH-1:0];
   assign wd_c      = bus.writedata[CNT_W-1:0];
   assign wd_unused = ^bus.writedata;

   always_comb begin
      data_d   = data_q;
      blink_d  = blink_q;
      period_d = period_q;
      run_d    = run_q;
      if (wr) begin
         case (addr)
            ADDR_DATA:   data_d   = wd_w;
            ADDR_BLINK:  blink_d  = wd_w;
            ADDR_PERIOD: period_d = wd_c;
            ADDR_CTRL:   run_d    = bus.writedata[CTRL_RUN];
            ADDR_OUTSET: data_d   = data_q | wd_w;
            ADDR_OUTCLR: data_d   = data_q & ~wd_w;
            ADDR_TOGGLE: data_d   = data_q ^ wd_w;
            default:     ;
         endcase
      end
   end

   assign period_load = wr && (addr == ADDR_PERIOD);

   led_blink_prescaler #(
      .CNT_W     (CNT_W),
      .RESET_CNT (DEFAULT_PERIOD)
   ) u_prescaler (
      .clk       (clk),
      .reset_n   (reset_n),
      .run       (run_q),
      .load      (period_load),
      .load_val  (period_d),
      .phase     (phase),
      .phase_nxt (phase_nxt)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q   <= RESET_VALUE;
         blink_q  <= '0;
         period_q <= DEFAULT_PERIOD;
         run_q    <= 1'b0;
         out_port <= RESET_VALUE;
      end else begin
         data_q   <= data_d;
         blink_q  <= blink_d;
         period_q <= period_d;
         run_q    <= run_d;
         // Built from next-state values so out_port lands one clock after the write.
         out_port <= data_d & ~(blink_d & {WIDTH{run_d & ~phase_nxt}});
      end
   end

   always_comb begin
      bus.readdata = '0;
      case (addr)
         ADDR_DATA:   bus.readdata = 32'(data_q);
         ADDR_BLINK:  bus.readdata = 32'(blink_q);
         ADDR_PERIOD: bus.readdata = 32'(period_q);
         ADDR_CTRL: begin
            bus.readdata[CTRL_RUN]   = run_q;
            bus.readdata[CTRL_PHASE] = phase;
         end
         default:     ;
      endcase
   end

endmodule
